// File: rtl/bin2bcd_seq_pkg.sv
// Shared display definitions for the binary-to-BCD converter and its digit corrector.
package bin2bcd_seq_pkg;

   localparam int unsigned BCD_DIGIT_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

   // Decimal digits of 2^bin_w - 1; 30103/100000 approximates log10(2).
   function automatic int unsigned min_digits(input int unsigned bin_w);
      return ((bin_w * 30103) / 100000) + 1;
   endfunction

endpackage

// File: rtl/bin2bcd_seq_add_3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more before the shift.
module bin2bcd_seq_add_3
   import bin2bcd_seq_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] din,
   output logic [BCD_DIGIT_W-1:0] dout_c
);

   always_comb begin
      dout_c = '0;
      case (din)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4: dout_c = din;
         4'd5, 4'd6, 4'd7, 4'd8, 4'd9: dout_c = din + 4'd3;
         default:                      dout_c = '0;
      endcase
   end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with start/busy/done handshake and a held result register.
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter int unsigned BIN_W  = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic [BIN_W-1:0]              bin,
   output logic                          busy,
   output logic                          done,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd
);

   localparam int unsigned SCR_W = BCD_DIGIT_W * DIGITS;
   localparam int unsigned CNT_W = $clog2(BIN_W + 1);

   if (BIN_W < 1 || DIGITS < min_digits(BIN_W)) begin : g_bad_params
      $error("bin2bcd_seq: DIGITS too small for BIN_W (or BIN_W < 1)");
   end

   state_e             state_q,  state_d;
   logic [BIN_W-1:0]   bin_sr_q, bin_sr_d;
   logic [SCR_W-1:0]   scr_q,    scr_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [SCR_W-1:0]   bcd_q,    bcd_d;
   logic               busy_q,   busy_d;
   logic               done_q,   done_d;
   logic [SCR_W-1:0]   corr;
   logic [SCR_W-1:0]   shifted;

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      bin2bcd_seq_add_3 u_add_3 (
         .din    (scr_q[i*BCD_DIGIT_W +: BCD_DIGIT_W]),
         .dout_c (corr[i*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
   end

   // Corrected scratch shifted left with the binary MSB entering bit 0; top carry is dropped.
   assign shifted = SCR_W'({corr, bin_sr_q[BIN_W-1]});

   always_comb begin
      state_d  = state_q;
      bin_sr_d = bin_sr_q;
      scr_d    = scr_q;
      cnt_d    = cnt_q;
      bcd_d    = bcd_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               bin_sr_d = bin;
               scr_d    = '0;
               cnt_d    = CNT_W'(BIN_W);
               busy_d   = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            bin_sr_d = bin_sr_q << 1;
            scr_d    = shifted;
            cnt_d    = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               bcd_d   = shifted;
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         bin_sr_q <= '0;
         scr_q    <= '0;
         cnt_q    <= '0;
         bcd_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bin_sr_q <= bin_sr_d;
         scr_q    <= scr_d;
         cnt_q    <= cnt_d;
         bcd_q    <= bcd_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign bcd  = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, handshake corner cases, and a
// full 0..255 sweep against a decimal reference model.
module tb_bin2bcd_seq;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  bin   = 8'd0;
   logic        busy;
   logic        done;
   logic [11:0] bcd;

   int          total    = 0;
   int          bad      = 0;
   int          done_cnt = 0;
   logic [11:0] prev_bcd = 12'h000;

   typedef struct {
      logic [7:0]  b;
      logic [11:0] exp;
   } vec_t;
   vec_t vecs [8];

   always #5 clk = ~clk;

   bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .bin   (bin),
      .busy  (busy),
      .done  (done),
      .bcd   (bcd)
   );

   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      int          x;
      r = 12'h000;
      x = v;
      for (int i = 0; i < 3; i++) begin
         r[i*4 +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Result must only move on done; scratch digits fed to the correctors must stay 0..9.
   always @(negedge clk) begin
      if (rst_n) begin
         if (done) done_cnt++;
         total++;
         if (!done && bcd !== prev_bcd) begin
            bad++;
            $display("FAIL bcd_hold: got %h want %h", bcd, prev_bcd);
         end
         for (int i = 0; i < 3; i++) begin
            total++;
            if (dut.scr_q[i*4 +: 4] > 4'd9) begin
               bad++;
               $display("FAIL add3_range: digit %0d got %0d want <=9", i, dut.scr_q[i*4 +: 4]);
            end
         end
      end
      prev_bcd = bcd;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   // Caller must be away from a rising edge; returns #1 after the cycle following done.
   task automatic do_conv(input logic [7:0] b, input logic [11:0] exp, input string name);
      int n;
      start = 1'b1;
      bin   = b;
      @(posedge clk); #1;
      start = 1'b0;
      bin   = 8'($urandom);
      chk({name, "_busy_on"}, 32'(busy), 32'd1);
      n = 0;
      while (!done && n < 12) begin
         @(posedge clk); #1;
         n++;
         if (!done) chk({name, "_busy_mid"}, 32'(busy), 32'd1);
      end
      chk({name, "_latency"}, 32'(n), 32'd8);
      chk({name, "_bcd"}, 32'(bcd), 32'(exp));
      chk({name, "_busy_off"}, 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk({name, "_done_pulse"}, 32'(done), 32'd0);
      chk({name, "_bcd_held"}, 32'(bcd), 32'(exp));
   endtask

   initial begin
      int d0;
      vecs[0] = '{8'd255, 12'h255};
      vecs[1] = '{8'd0,   12'h000};
      vecs[2] = '{8'd99,  12'h099};
      vecs[3] = '{8'd100, 12'h100};
      vecs[4] = '{8'd1,   12'h001};
      vecs[5] = '{8'd10,  12'h010};
      vecs[6] = '{8'd9,   12'h009};
      vecs[7] = '{8'd128, 12'h128};

      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd",  32'(bcd),  32'd0);

      // First conversion starts on the very first edge after reset release.
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if (i > 0) @(negedge clk);
         do_conv(vecs[i].b, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // Start accepted in the done cycle.
      @(negedge clk);
      d0 = done_cnt;
      start = 1'b1; bin = 8'd128;
      @(posedge clk); #1;
      start = 1'b0; bin = 8'd55;
      repeat (7) @(posedge clk);
      #1;
      chk("b2b_early_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("b2b_done1", 32'(done), 32'd1);
      chk("b2b_bcd1",  32'(bcd),  32'h128);
      start = 1'b1; bin = 8'd7;
      @(posedge clk); #1;
      start = 1'b0; bin = 8'd99;
      chk("b2b_busy2", 32'(busy), 32'd1);
      repeat (7) @(posedge clk);
      #1;
      chk("b2b_bcd_mid", 32'(bcd), 32'h128);
      @(posedge clk); #1;
      chk("b2b_done2", 32'(done), 32'd1);
      chk("b2b_bcd2",  32'(bcd),  32'h007);
      @(negedge clk); #1;
      chk("b2b_pulses", 32'(done_cnt - d0), 32'd2);

      // Start while busy is ignored and not queued.
      @(negedge clk);
      d0 = done_cnt;
      start = 1'b1; bin = 8'd42;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; bin = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("ign_early_done", 32'(done), 32'd0);
      @(posedge clk); #1;
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_bcd",  32'(bcd),  32'h042);
      repeat (10) @(posedge clk);
      #1;
      chk("ign_bcd_late", 32'(bcd),  32'h042);
      chk("ign_busy",     32'(busy), 32'd0);
      chk("ign_pulses",   32'(done_cnt - d0), 32'd1);

      // Reset mid-conversion aborts immediately.
      @(negedge clk);
      start = 1'b1; bin = 8'd200;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_bcd",  32'(bcd),  32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("abort_no_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_conv(8'd13, 12'h013, "post_rst");

      // Full sweep with random idle gaps.
      for (int v = 0; v < 256; v++) begin
         repeat (1 + $urandom_range(0, 3)) @(negedge clk);
         do_conv(8'(v), ref_bcd(v), $sformatf("sweep%0d", v));
      end

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
